// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types and constants.
// Master ids and the AXI4 burst length width.
package axi_ic_pkg;

  localparam int AXI_LEN_W = 8;

  typedef logic mst_id_t;

  localparam mst_id_t MST_S00 = 1'b0;
  localparam mst_id_t MST_S01 = 1'b1;

endpackage

// File: rtl/wd_order_ctrl_if.sv
// AW-grant push and W-path handshake bundle of wd_order_ctrl.
// master: interconnect side driving it; slave: the controller.
interface wd_order_ctrl_if
  import axi_ic_pkg::*;
#(
  parameter int AW_LEN_WIDTH = AXI_LEN_W
);

  logic                    aw_push;
  mst_id_t                 aw_master_id;
  logic [AW_LEN_WIDTH-1:0] aw_len;
  logic                    aw_accept;
  logic                    Selected_Slave;
  logic                    Sel_S_AXI_wvalid;
  logic                    Sel_S_AXI_wlast;
  logic                    M_AXI_wvalid;
  logic                    M_AXI_wready;
  logic                    S00_AXI_wready;
  logic                    S01_AXI_wready;
  logic                    wr_len_err;

  modport master (
    output aw_push,
    output aw_master_id,
    output aw_len,
    output Sel_S_AXI_wvalid,
    output Sel_S_AXI_wlast,
    output M_AXI_wready,
    input  aw_accept,
    input  Selected_Slave,
    input  M_AXI_wvalid,
    input  S00_AXI_wready,
    input  S01_AXI_wready,
    input  wr_len_err
  );

  modport slave (
    input  aw_push,
    input  aw_master_id,
    input  aw_len,
    input  Sel_S_AXI_wvalid,
    input  Sel_S_AXI_wlast,
    input  M_AXI_wready,
    output aw_accept,
    output Selected_Slave,
    output M_AXI_wvalid,
    output S00_AXI_wready,
    output S01_AXI_wready,
    output wr_len_err
  );

endinterface

// File: rtl/wd_order_fifo.sv
// Circular FIFO with head peek, full/empty and count.
// Ports: clk, rst_n, push, pop, din -> head, full, empty, count.
module wd_order_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // full is a registered-state decode: a pop in the
  // same cycle does not reopen the queue.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wd_order_ctrl.sv
// Write-data ordering controller: W beats follow AW grant order.
// Ports: ACLK, ARESETN, bus (slave). Option: WD_BEAT_CHECK_EN.
module wd_order_ctrl
  import axi_ic_pkg::*;
#(
  parameter int WD_FIFO_DEPTH = 4,
  parameter int AW_LEN_WIDTH  = AXI_LEN_W
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  wd_order_ctrl_if.slave  bus
);

`ifdef WD_BEAT_CHECK_EN
  localparam int EW = 1 + AW_LEN_WIDTH;
`else
  localparam int EW = 1;
`endif

  logic [EW-1:0]               din;
  logic [EW-1:0]               head;
  logic                        full;
  logic                        empty;
  logic [$clog2(WD_FIFO_DEPTH):0] count;
  logic                        active;
  mst_id_t                     head_id;
  mst_id_t                     sel;
  mst_id_t                     sel_q;
  logic                        beat;
  logic                        pop;

`ifdef WD_BEAT_CHECK_EN
  assign din = {bus.aw_master_id, bus.aw_len};
`else
  assign din = bus.aw_master_id;
  logic unused_len;
  assign unused_len = &{1'b0, bus.aw_len, count};
`endif

  wd_order_fifo #(
    .DEPTH (WD_FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (bus.aw_push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign active  = !empty;
  assign head_id = head[EW-1];

  // Hold the last head on empty so the mux does not toggle idle.
  assign sel = active ? head_id : sel_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sel_q <= MST_S00;
    end else begin
      sel_q <= sel;
    end
  end

  assign beat = bus.M_AXI_wvalid && bus.M_AXI_wready;
  assign pop  = beat && bus.Sel_S_AXI_wlast;

  assign bus.aw_accept      = !full;
  assign bus.Selected_Slave = sel;
  assign bus.M_AXI_wvalid   = bus.Sel_S_AXI_wvalid && active;
  assign bus.S00_AXI_wready = bus.M_AXI_wready && active &&
                              (head_id == MST_S00);
  assign bus.S01_AXI_wready = bus.M_AXI_wready && active &&
                              (head_id == MST_S01);

`ifdef WD_BEAT_CHECK_EN
  logic [AW_LEN_WIDTH-1:0] head_len;
  logic [AW_LEN_WIDTH-1:0] beat_cnt;
  logic                    err_q;
  logic                    unused_cnt;

  assign head_len   = head[AW_LEN_WIDTH-1:0];
  assign unused_cnt = &{1'b0, count};

  // beat_cnt holds beats already taken in the head burst.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= beat && (bus.Sel_S_AXI_wlast ?
                        (beat_cnt != head_len) :
                        (beat_cnt == head_len));
      if (pop) begin
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign bus.wr_len_err = err_q;
`else
  assign bus.wr_len_err = 1'b0;
`endif

endmodule
